// File: rtl/filtro_iir_biquad_multicanal.sv
// Multi-channel Direct-Form-I biquad IIR filter with run-time coefficients.
// A single multiply-accumulate unit is shared across all channels, one term
// per clock. The result is rounded half-up and saturated to the N-bit range.
//
// state  | meaning
// -------+-------------------------------------------------------------
// REPOSO | idle, waiting for an ADC strobe on a valid channel
// MAC    | accumulating the five products, one per clock (k = 0..4)
// SALIDA | round/clip, publish Yk, shift the channel history
module filtro_iir_biquad_multicanal #(
  parameter int N  = 25,
  parameter int F  = 20,
  parameter int CH = 4,
  parameter int CW = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Bandera_ADC,
  input  logic [N-1:0]  Uk,
  input  logic [CW-1:0] Canal,
  input  logic          Limpiar,
  input  logic          Coef_We,
  input  logic [2:0]    Coef_Addr,
  input  logic [N-1:0]  Coef_Data,
  output logic [N-1:0]  Yk,
  output logic [CW-1:0] Canal_Out,
  output logic          Bandera_Listo,
  output logic          Ocupado,
  output logic          Perdido,
  output logic          Saturado
);

  localparam int AW = 2*N + 3;
  localparam int PW = 2*N;
  localparam logic [N-1:0]         COEF_UNO = N'(1) << F;
  localparam logic signed [AW-1:0] RND      = AW'(1) << (F-1);
  localparam logic signed [AW-1:0] Y_MAX    = (AW'(1) << (N-1)) - AW'(1);
  localparam logic signed [AW-1:0] Y_MIN    = -(AW'(1) << (N-1));

  typedef enum logic [1:0] {REPOSO, MAC, SALIDA} estado_t;
  estado_t estado, estado_sig;

  logic [N-1:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic [N-1:0] hist_x1 [CH];
  logic [N-1:0] hist_x2 [CH];
  logic [N-1:0] hist_y1 [CH];
  logic [N-1:0] hist_y2 [CH];

  logic [N-1:0]          x_reg;
  logic [CW-1:0]         ch_reg;
  logic [2:0]            k;
  logic signed [AW-1:0]  acc;

  logic                  canal_ok, acepta;
  logic [N-1:0]          coef_sel, dato_sel;
  logic signed [PW-1:0]  op_a, op_b, prod;
  logic signed [AW-1:0]  termino, acc_sig, acc_rnd, r_val;
  logic [N-1:0]          y_clip;
  logic                  sat_flag;

  assign canal_ok = (32'(Canal) < 32'(CH));
  assign acepta   = (estado == REPOSO) && Bandera_ADC && canal_ok && !Limpiar;

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // Next-state logic; Limpiar aborts from any state
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO: if (acepta) estado_sig = MAC;
      MAC:    if (k == 3'd4) estado_sig = SALIDA;
      SALIDA: estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
    if (Limpiar) estado_sig = REPOSO;
  end

  // Operand selection and signed MAC; feedback terms (k = 3, 4) are subtracted
  always_comb begin
    coef_sel = '0;
    dato_sel = '0;
    case (k)
      3'd0: begin coef_sel = coef_b0; dato_sel = x_reg;           end
      3'd1: begin coef_sel = coef_b1; dato_sel = hist_x1[ch_reg]; end
      3'd2: begin coef_sel = coef_b2; dato_sel = hist_x2[ch_reg]; end
      3'd3: begin coef_sel = coef_a1; dato_sel = hist_y1[ch_reg]; end
      3'd4: begin coef_sel = coef_a2; dato_sel = hist_y2[ch_reg]; end
      default: ;
    endcase
    op_a    = PW'($signed(coef_sel));
    op_b    = PW'($signed(dato_sel));
    prod    = op_a * op_b;
    termino = AW'(prod);
    acc_sig = (k >= 3'd3) ? (acc - termino) : (acc + termino);
  end

  // Round half up, drop fractional bits, clip to the output range
  always_comb begin
    acc_rnd  = acc + RND;
    r_val    = acc_rnd >>> F;
    sat_flag = 1'b0;
    y_clip   = r_val[N-1:0];
    if (r_val > Y_MAX) begin
      y_clip   = Y_MAX[N-1:0];
      sat_flag = 1'b1;
    end else if (r_val < Y_MIN) begin
      y_clip   = Y_MIN[N-1:0];
      sat_flag = 1'b1;
    end
  end

  // Datapath, coefficient bank, channel histories and output flags
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      coef_b0       <= COEF_UNO;
      coef_b1       <= '0;
      coef_b2       <= '0;
      coef_a1       <= '0;
      coef_a2       <= '0;
      for (int i = 0; i < CH; i++) begin
        hist_x1[i] <= '0;
        hist_x2[i] <= '0;
        hist_y1[i] <= '0;
        hist_y2[i] <= '0;
      end
      x_reg         <= '0;
      ch_reg        <= '0;
      k             <= '0;
      acc           <= '0;
      Yk            <= '0;
      Canal_Out     <= '0;
      Bandera_Listo <= 1'b0;
      Ocupado       <= 1'b0;
      Perdido       <= 1'b0;
      Saturado      <= 1'b0;
    end else begin
      Bandera_Listo <= 1'b0;
      Saturado      <= 1'b0;
      Perdido       <= Bandera_ADC && Ocupado && !Limpiar;

      if (Coef_We && !Ocupado) begin
        case (Coef_Addr)
          3'd0: coef_b0 <= Coef_Data;
          3'd1: coef_b1 <= Coef_Data;
          3'd2: coef_b2 <= Coef_Data;
          3'd3: coef_a1 <= Coef_Data;
          3'd4: coef_a2 <= Coef_Data;
          default: ;
        endcase
      end

      if (Limpiar) begin
        for (int i = 0; i < CH; i++) begin
          hist_x1[i] <= '0;
          hist_x2[i] <= '0;
          hist_y1[i] <= '0;
          hist_y2[i] <= '0;
        end
        Ocupado <= 1'b0;
      end else begin
        case (estado)
          REPOSO: begin
            if (acepta) begin
              x_reg   <= Uk;
              ch_reg  <= Canal;
              acc     <= '0;
              k       <= '0;
              Ocupado <= 1'b1;
            end
          end
          MAC: begin
            acc <= acc_sig;
            k   <= k + 3'd1;
          end
          SALIDA: begin
            Yk              <= y_clip;
            Canal_Out       <= ch_reg;
            Saturado        <= sat_flag;
            Bandera_Listo   <= 1'b1;
            hist_x2[ch_reg] <= hist_x1[ch_reg];
            hist_x1[ch_reg] <= x_reg;
            hist_y2[ch_reg] <= hist_y1[ch_reg];
            hist_y1[ch_reg] <= y_clip;
            Ocupado         <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_filtro_iir_biquad_multicanal.sv
// Self-checking bench: table of reference vectors plus a behavioural model;
// expected results are queued at stimulus time and popped on Bandera_Listo.
module tb_filtro_iir_biquad_multicanal;
  localparam int N  = 25;
  localparam int F  = 20;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam int NV = 15;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Bandera_ADC;
  logic [N-1:0]  Uk;
  logic [CW-1:0] Canal;
  logic          Limpiar;
  logic          Coef_We;
  logic [2:0]    Coef_Addr;
  logic [N-1:0]  Coef_Data;
  logic [N-1:0]  Yk;
  logic [CW-1:0] Canal_Out;
  logic          Bandera_Listo, Ocupado, Perdido, Saturado;

  filtro_iir_biquad_multicanal #(.N(N), .F(F), .CH(CH), .CW(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Bandera_ADC(Bandera_ADC), .Uk(Uk), .Canal(Canal),
    .Limpiar(Limpiar), .Coef_We(Coef_We), .Coef_Addr(Coef_Addr), .Coef_Data(Coef_Data),
    .Yk(Yk), .Canal_Out(Canal_Out), .Bandera_Listo(Bandera_Listo), .Ocupado(Ocupado),
    .Perdido(Perdido), .Saturado(Saturado)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [CW-1:0] ch;
    logic [N-1:0]  uk;
    logic [N-1:0]  y;
    logic          sat;
  } vec_t;

  typedef struct {
    logic [CW-1:0] ch;
    logic [N-1:0]  y;
    logic          sat;
  } exp_t;

  vec_t tabla [NV];
  exp_t sb [$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  longint cm [5];
  longint mx1 [CH], mx2 [CH], my1 [CH], my2 [CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_hist_clear();
    for (int i = 0; i < CH; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
  endfunction

  function automatic void model_reset();
    cm[0] = longint'(1) << F;
    for (int i = 1; i < 5; i++) cm[i] = 0;
    model_hist_clear();
  endfunction

  function automatic void model_step(input int ch, input logic [N-1:0] uk,
                                     output logic [N-1:0] y, output logic sat);
    longint x, acc, r;
    longint ymax, ymin;
    ymax = (longint'(1) << (N-1)) - 1;
    ymin = -(longint'(1) << (N-1));
    x    = longint'($signed(uk));
    acc  = cm[0]*x + cm[1]*mx1[ch] + cm[2]*mx2[ch] - cm[3]*my1[ch] - cm[4]*my2[ch];
    r    = (acc + (longint'(1) << (F-1))) >>> F;
    sat  = 1'b0;
    if (r > ymax) begin r = ymax; sat = 1'b1; end
    else if (r < ymin) begin r = ymin; sat = 1'b1; end
    mx2[ch] = mx1[ch]; mx1[ch] = x;
    my2[ch] = my1[ch]; my1[ch] = r;
    y = r[N-1:0];
  endfunction

  // Scoreboard consumer: every result must match the oldest queued expectation
  always @(negedge Clk) begin
    if (Bandera_Listo === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_listo: got Yk=0x%0h Canal_Out=%0d, expected no output", Yk, Canal_Out);
      end else begin
        mon_e = sb.pop_front();
        check("yk", 64'(Yk), 64'(mon_e.y));
        check("canal_out", 64'(Canal_Out), 64'(mon_e.ch));
        check("saturado", 64'(Saturado), 64'(mon_e.sat));
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse(input logic [CW-1:0] ch, input logic [N-1:0] uk);
    Bandera_ADC = 1'b1;
    Uk          = uk;
    Canal       = ch;
    tick();
    Bandera_ADC = 1'b0;
  endtask

  task automatic wait_listo(input int exp_edges);
    int n;
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (Bandera_Listo === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL listo_timeout: got no Bandera_Listo within 16 clocks, expected after %0d", exp_edges);
    end else begin
      check("latency", 64'(n), 64'(exp_edges));
    end
  endtask

  task automatic wr_coef(input logic [2:0] addr, input logic [N-1:0] data);
    Coef_We   = 1'b1;
    Coef_Addr = addr;
    Coef_Data = data;
    tick();
    Coef_We   = 1'b0;
    if (addr <= 3'd4) cm[addr] = longint'($signed(data));
  endtask

  task automatic do_limpiar();
    Limpiar = 1'b1;
    tick();
    Limpiar = 1'b0;
    model_hist_clear();
  endtask

  task automatic push_exp(input logic [CW-1:0] ch, input logic [N-1:0] y, input logic sat);
    exp_t e;
    e.ch = ch; e.y = y; e.sat = sat;
    sb.push_back(e);
  endtask

  task automatic run_vec(input int i);
    logic [N-1:0] my;
    logic         ms;
    model_step(int'(tabla[i].ch), tabla[i].uk, my, ms);
    push_exp(tabla[i].ch, tabla[i].y, tabla[i].sat);
    pulse(tabla[i].ch, tabla[i].uk);
    wait_listo(6);
  endtask

  task automatic queue_model(input logic [CW-1:0] ch, input logic [N-1:0] uk);
    logic [N-1:0] my;
    logic         ms;
    model_step(int'(ch), uk, my, ms);
    push_exp(ch, my, ms);
  endtask

  task automatic run_model(input logic [CW-1:0] ch, input logic [N-1:0] uk);
    queue_model(ch, uk);
    pulse(ch, uk);
    wait_listo(6);
  endtask

  initial begin
    // pass-through after reset
    tabla[0]  = '{2'd0, 25'h0001234, 25'h0001234, 1'b0};
    // impulse on channel 1
    tabla[1]  = '{2'd1, 25'h0100000, 25'h0080000, 1'b0};
    tabla[2]  = '{2'd1, 25'h0000000, 25'h0080000, 1'b0};
    tabla[3]  = '{2'd1, 25'h0000000, 25'h0040000, 1'b0};
    tabla[4]  = '{2'd1, 25'h0000000, 25'h0020000, 1'b0};
    // saturation with b0 = b1 = 1.0
    tabla[5]  = '{2'd0, 25'h0FFFFFF, 25'h0FFFFFF, 1'b0};
    tabla[6]  = '{2'd0, 25'h0FFFFFF, 25'h0FFFFFF, 1'b1};
    tabla[7]  = '{2'd0, 25'h1000000, 25'h1FFFFFF, 1'b0};
    tabla[8]  = '{2'd0, 25'h1000000, 25'h1000000, 1'b1};
    // rounding with b0 = 0.5 only
    tabla[9]  = '{2'd3, 25'h0000001, 25'h0000001, 1'b0};
    tabla[10] = '{2'd3, 25'h1FFFFFF, 25'h0000000, 1'b0};
    tabla[11] = '{2'd3, 25'h0000003, 25'h0000002, 1'b0};
    tabla[12] = '{2'd3, 25'h1FFFFFD, 25'h1FFFFFF, 1'b0};
    // pass-through restored by a reset during computation
    tabla[13] = '{2'd0, 25'h0012345, 25'h0012345, 1'b0};
    tabla[14] = '{2'd0, 25'h1FFFF00, 25'h1FFFF00, 1'b0};

    Rst_n = 1'b0; Bandera_ADC = 1'b0; Uk = '0; Canal = '0; Limpiar = 1'b0;
    Coef_We = 1'b0; Coef_Addr = '0; Coef_Data = '0;
    model_reset();
    repeat (3) tick();
    check("rst_yk", 64'(Yk), 64'h0);
    check("rst_canal_out", 64'(Canal_Out), 64'h0);
    check("rst_listo", 64'(Bandera_Listo), 64'h0);
    check("rst_ocupado", 64'(Ocupado), 64'h0);
    check("rst_perdido", 64'(Perdido), 64'h0);
    check("rst_saturado", 64'(Saturado), 64'h0);
    Rst_n = 1'b1;
    tick();

    run_vec(0);

    wr_coef(3'd0, 25'h0080000);
    wr_coef(3'd1, 25'h0040000);
    wr_coef(3'd2, 25'h0000000);
    wr_coef(3'd3, 25'h1F80000);
    wr_coef(3'd4, 25'h0000000);
    for (int i = 1; i <= 4; i++) run_vec(i);

    // interleaved channels: ch1 impulse must be unaffected by ch2 activity
    do_limpiar();
    for (int i = 1; i <= 4; i++) begin
      run_vec(i);
      run_model(2'd2, 25'h0010000);
    end
    for (int i = 0; i < 6; i++) run_model(2'd2, 25'h0010000);

    // overrun three clocks after the accepted strobe
    queue_model(2'd0, 25'h0033333);
    pulse(2'd0, 25'h0033333);
    tick(); tick();
    pulse(2'd1, 25'h0155555);
    check("overrun_perdido", 64'(Perdido), 64'h1);
    check("overrun_ocupado", 64'(Ocupado), 64'h1);
    tick();
    check("perdido_pulse_end", 64'(Perdido), 64'h0);
    wait_listo(2);

    // strobe on the output edge is dropped, strobe in the Listo cycle accepted
    queue_model(2'd0, 25'h0022222);
    pulse(2'd0, 25'h0022222);
    repeat (5) tick();
    pulse(2'd2, 25'h0011111);
    check("e6_perdido", 64'(Perdido), 64'h1);
    check("e6_listo", 64'(Bandera_Listo), 64'h1);
    run_model(2'd0, 25'h1FF0000);
    repeat (10) tick();

    // coefficient writes while busy or to an unused address are ignored
    queue_model(2'd3, 25'h0100000);
    pulse(2'd3, 25'h0100000);
    Coef_We = 1'b1; Coef_Addr = 3'd0; Coef_Data = 25'h0ABCDE;
    tick();
    Coef_We = 1'b0;
    wait_listo(5);
    wr_coef(3'd5, 25'h0123456);
    run_model(2'd3, 25'h0100000);

    // Limpiar aborts an ongoing computation
    pulse(2'd1, 25'h0100000);
    tick(); tick();
    Limpiar = 1'b1;
    tick();
    Limpiar = 1'b0;
    model_hist_clear();
    check("limpiar_ocupado", 64'(Ocupado), 64'h0);
    repeat (8) tick();
    run_vec(1);

    // asynchronous reset mid-computation
    pulse(2'd0, 25'h0040000);
    tick(); tick();
    Rst_n = 1'b0;
    #1;
    check("arst_ocupado", 64'(Ocupado), 64'h0);
    check("arst_yk", 64'(Yk), 64'h0);
    tick();
    check("arst_listo", 64'(Bandera_Listo), 64'h0);
    Rst_n = 1'b1;
    model_reset();
    tick();
    run_vec(13);
    run_vec(14);

    wr_coef(3'd0, 25'h0100000);
    wr_coef(3'd1, 25'h0100000);
    do_limpiar();
    for (int i = 5; i <= 8; i++) run_vec(i);

    wr_coef(3'd0, 25'h0080000);
    wr_coef(3'd1, 25'h0000000);
    for (int i = 9; i <= 12; i++) run_vec(i);

    repeat (10) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule
